// File: rtl/alu_pkg.sv
// Shared types for the ALU control-line interface and the CB-prefix rotate/shift sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        NO_SH = 2'd0,
        L_SH  = 2'd1,
        R_SH  = 2'd2
    } sh_t;

    typedef enum logic [1:0] {
        NO_OE  = 2'd0,
        SH_OE  = 2'd1,
        RES_OE = 2'd2
    } oe_t;

    typedef enum logic {
        NO_LD  = 1'b0,
        BUS_LD = 1'b1
    } ld_t;

    typedef enum logic [2:0] {
        CB_RLC  = 3'd0,
        CB_RRC  = 3'd1,
        CB_RL   = 3'd2,
        CB_RR   = 3'd3,
        CB_SLA  = 3'd4,
        CB_SRA  = 3'd5,
        CB_SWAP = 3'd6,
        CB_SRL  = 3'd7
    } cb_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RES  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       si;
        sh_t        sh;
        oe_t        oe;
        ld_t        la;
        ld_t        lb;
        logic       r;
        logic       s;
        logic       v;
        logic       ne;
        logic       ci;
        logic       l;
        logic       h;
    } alu_line_t;

    localparam alu_line_t IDLE_LINE = '{
        op: 3'd0, si: 1'b0, sh: NO_SH, oe: NO_OE, la: NO_LD, lb: NO_LD,
        r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0
    };

endpackage

// File: rtl/alu_shift_seq_shift_in_sel.sv
// Picks shift direction and the bit shifted into the vacated end for each CB rotate/shift op.
module shift_in_sel
    import alu_pkg::*;
(
    input  cb_op_t     op,
    input  logic [7:0] b,
    input  logic       cin,
    output sh_t        sh,
    output logic       si
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        sh = NO_SH;
        si = 1'b0;
        unique case (op)
            CB_RLC:  begin sh = L_SH; si = b[7]; end
            CB_RRC:  begin sh = R_SH; si = b[0]; end
            CB_RL:   begin sh = L_SH; si = cin;  end
            CB_RR:   begin sh = R_SH; si = cin;  end
            CB_SLA:  begin sh = L_SH; si = 1'b0; end
            CB_SRA:  begin sh = R_SH; si = b[7]; end
            CB_SRL:  begin sh = R_SH; si = 1'b0; end
            default: begin sh = NO_SH; si = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Drives the ALU control line through a LOAD/RES sequence for one CB rotate/shift op and
// captures the result and Z/C flags for the CPU sequencer.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter bit BACK2BACK = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] operand,
    input  logic       cin,
    output alu_line_t  alu_line,
    input  logic       shift_co,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [7:0] result,
    output logic [3:0] flags
);

    seq_state_t state, state_nxt;
    cb_op_t     op_q;
    logic [7:0] operand_q;
    logic       cin_q;
    logic       c_q;
    logic       accept;
    logic       reject;
    sh_t        sel_sh;
    logic       sel_si;

    shift_in_sel u_shift_in_sel (
        .op  (op_q),
        .b   (operand_q),
        .cin (cin_q),
        .sh  (sel_sh),
        .si  (sel_si)
    );

    assign ready  = (state == S_IDLE) || (BACK2BACK && (state == S_DONE));
    assign done   = (state == S_DONE);
    assign accept = start && ready && (op != CB_SWAP);
    assign reject = start && ready && (op == CB_SWAP);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_RES;
            S_RES:  state_nxt = S_DONE;
            S_DONE: state_nxt = (BACK2BACK && accept) ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_line = IDLE_LINE;
        unique case (state)
            S_LOAD: begin
                alu_line.op = op_q;
                alu_line.la = BUS_LD;
                alu_line.lb = BUS_LD;
                alu_line.oe = SH_OE;
                alu_line.sh = sel_sh;
                alu_line.si = sel_si;
                alu_line.r  = 1'b1;
                alu_line.s  = 1'b1;
                alu_line.v  = 1'b1;
                alu_line.l  = 1'b1;
            end
            S_RES: begin
                alu_line.op = op_q;
                alu_line.oe = RES_OE;
                alu_line.r  = 1'b1;
                alu_line.s  = 1'b1;
                alu_line.v  = 1'b1;
                alu_line.h  = 1'b1;
            end
            default: alu_line = IDLE_LINE;
        endcase
    end

    // NOTE: state is assigned with <= so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            err    <= 1'b0;
            result <= 8'h00;
            flags  <= 4'h0;
        end else begin
            state <= state_nxt;
            err   <= reject;
            if (state == S_RES) begin
                result <= alu_result;
                flags  <= {alu_zero, 1'b0, 1'b0, c_q};
            end
        end
    end

    // NOTE: request and carry capture registers are not reset; they are only read after a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= cb_op_t'(op);
            operand_q <= operand;
            cin_q     <= cin;
        end
        if (state == S_LOAD) c_q <= shift_co;
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench: a bench-side ALU responder/model feeds the DUT and a per-cycle compare checks it.
module tb_alu_shift_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] op;
    logic [7:0] operand;
    logic       cin;
    alu_line_t  alu_line;
    logic       shift_co;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic [3:0] flags;

    alu_shift_seq #(.BACK2BACK(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .operand    (operand),
        .cin        (cin),
        .alu_line   (alu_line),
        .shift_co   (shift_co),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .result     (result),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    logic       e_ready, e_done, e_err;
    logic [7:0] e_result;
    logic [3:0] e_flags;
    alu_line_t  e_line;
    logic [7:0] m_result;
    logic [3:0] m_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics of each rotate/shift: result byte, carry out, direction, shift-in bit.
    function automatic void ref_model(input logic [2:0] o, input logic [7:0] b, input logic c,
                                      output logic [7:0] r, output logic co,
                                      output sh_t sh, output logic si);
        r = 8'h00; co = 1'b0; sh = NO_SH; si = 1'b0;
        case (o)
            3'd0: begin r = 8'((b << 1) | (b >> 7));            co = b[7]; sh = L_SH; si = b[7]; end
            3'd1: begin r = 8'((b >> 1) | (b << 7));            co = b[0]; sh = R_SH; si = b[0]; end
            3'd2: begin r = 8'((b << 1) | {7'd0, c});           co = b[7]; sh = L_SH; si = c;    end
            3'd3: begin r = 8'((b >> 1) | {c, 7'd0});           co = b[0]; sh = R_SH; si = c;    end
            3'd4: begin r = 8'(b << 1);                         co = b[7]; sh = L_SH; si = 1'b0; end
            3'd5: begin r = 8'((b >> 1) | (b & 8'h80));         co = b[0]; sh = R_SH; si = b[7]; end
            3'd7: begin r = 8'(b >> 1);                         co = b[0]; sh = R_SH; si = 1'b0; end
            default: ;
        endcase
    endfunction

    function automatic alu_line_t exp_line(input logic [2:0] o, input sh_t sh, input logic si,
                                           input bit load);
        alu_line_t x;
        x = IDLE_LINE;
        x.op = o; x.r = 1'b1; x.s = 1'b1; x.v = 1'b1;
        if (load) begin
            x.la = BUS_LD; x.lb = BUS_LD; x.oe = SH_OE; x.sh = sh; x.si = si; x.l = 1'b1;
        end else begin
            x.oe = RES_OE; x.h = 1'b1;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",    {31'd0, ready}, {31'd0, e_ready});
            check("done",     {31'd0, done},  {31'd0, e_done});
            check("err",      {31'd0, err},   {31'd0, e_err});
            check("result",   {24'd0, result}, {24'd0, e_result});
            check("flags",    {28'd0, flags},  {28'd0, e_flags});
            check("alu_line", {15'd0, alu_line}, {15'd0, e_line});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0; e_line = IDLE_LINE;
        e_result = m_result; e_flags = m_flags;
    endtask

    task automatic idle();
        step();
        start = 1'b0;
        set_idle_exp();
    endtask

    // Issues one op in the current cycle; returns positioned in its DONE cycle (or the
    // post-reset cycle when aborted) with start low.
    task automatic do_op(input logic [2:0] o, input logic [7:0] b, input logic c,
                         input bit hold, input bit abort);
        logic [7:0] r;
        logic       co, si;
        sh_t        sh;
        ref_model(o, b, c, r, co, sh, si);
        start = 1'b1; op = o; operand = b; cin = c;
        shift_co = ~co; alu_result = ~r; alu_zero = (r != 8'h00);
        step();
        start = hold; op = o ^ 3'd1; operand = ~b; cin = ~c;
        shift_co = co; alu_result = ~r; alu_zero = (r != 8'h00);
        e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0;
        e_line = exp_line(o, sh, si, 1'b1);
        step();
        shift_co = ~co; alu_result = r; alu_zero = (r == 8'h00);
        e_line = exp_line(o, sh, si, 1'b0);
        if (abort) reset_n = 1'b0;
        step();
        start = 1'b0;
        shift_co = 1'b0; alu_result = 8'h5A; alu_zero = 1'b0;
        if (abort) begin
            reset_n  = 1'b1;
            m_result = 8'h00;
            m_flags  = 4'h0;
            set_idle_exp();
        end else begin
            m_result = r;
            m_flags  = {(r == 8'h00), 2'b00, co};
            set_idle_exp();
            e_done = 1'b1;
        end
    endtask

    task automatic do_swap();
        start = 1'b1; op = 3'd6; operand = 8'hA5; cin = 1'b0;
        step();
        start = 1'b0;
        set_idle_exp();
        e_err = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 3'd0; operand = 8'h00; cin = 1'b0;
        shift_co = 1'b0; alu_result = 8'h00; alu_zero = 1'b0;
        m_result = 8'h00; m_flags = 4'h0;
        step();
        set_idle_exp();
        chk_en = 1'b1;
        step();
        reset_n = 1'b1;
        idle();

        do_op(3'd0, 8'h85, 1'b0, 1'b0, 1'b0);
        check("rlc_result", {24'd0, result}, 32'h0B);
        check("rlc_flags",  {28'd0, flags},  32'b0001);
        idle();
        do_op(3'd1, 8'h01, 1'b0, 1'b0, 1'b0);
        check("rrc_result", {24'd0, result}, 32'h80);
        check("rrc_flags",  {28'd0, flags},  32'b0001);
        idle();
        do_op(3'd3, 8'h01, 1'b0, 1'b0, 1'b0);
        check("rr_result", {24'd0, result}, 32'h00);
        check("rr_flags",  {28'd0, flags},  32'b1001);
        idle();
        do_op(3'd5, 8'h81, 1'b0, 1'b0, 1'b0);
        check("sra_result", {24'd0, result}, 32'hC0);
        check("sra_flags",  {28'd0, flags},  32'b0001);
        idle();
        do_op(3'd4, 8'h80, 1'b0, 1'b0, 1'b0);
        check("sla_result", {24'd0, result}, 32'h00);
        check("sla_flags",  {28'd0, flags},  32'b1001);
        idle();

        do_swap();
        check("swap_err", {31'd0, err}, 32'd1);
        idle();
        idle();

        do_op(3'd2, 8'h3C, 1'b1, 1'b1, 1'b0);
        check("rl_hold_result", {24'd0, result}, 32'h79);
        idle();
        do_op(3'd7, 8'h01, 1'b0, 1'b1, 1'b0);
        do_op(3'd2, 8'h80, 1'b0, 1'b0, 1'b0);
        check("b2b_rl_result", {24'd0, result}, 32'h00);
        check("b2b_rl_flags",  {28'd0, flags},  32'b1001);
        do_op(3'd1, 8'h02, 1'b1, 1'b0, 1'b0);
        check("b2b_rrc_result", {24'd0, result}, 32'h01);
        idle();

        do_op(3'd2, 8'hFF, 1'b0, 1'b0, 1'b1);
        check("abort_done",   {31'd0, done},  32'd0);
        check("abort_result", {24'd0, result}, 32'h00);
        idle();
        do_op(3'd3, 8'h80, 1'b1, 1'b0, 1'b0);
        check("rr_cin_result", {24'd0, result}, 32'hC0);
        check("rr_cin_flags",  {28'd0, flags},  32'b0000);
        idle();
        idle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
